fma_issue_scheduler: RTL

//  Issue-slot scheduler in front of one FMA slice (FMUL -> FADD pipeline with a shared adder input and one writeback port).

---
 rtl/fma_issue_scheduler_if.sv | 38 +++
 rtl/fma_issue_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fma_issue_scheduler_if.sv
// ----------------------------------------------------------------------------
// fma_issue_scheduler_if
// Bundle between the issue queue head and the FMA issue scheduler.
//   req_valid/req_op/req_tag : head op offered for issue (op 0=ADD 1=MUL 2=MADD)
//   req_ready                : grant, issue on req_valid & req_ready
//   flush                    : backend redirect, squashes in-flight predictions
//   wake_valid/wake_tag      : an op writes back next cycle
//   wb_valid/wb_tag          : an op writes back this cycle
//   inflight                 : ops granted but not yet drained
//   stall_cnt                : saturating count of blocked valid cycles
// master = issue side, slave = scheduler.
// ----------------------------------------------------------------------------
interface fma_issue_scheduler_if #(
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned STALL_W = 16
) ();
    logic               req_valid;
    logic [1:0]         req_op;
    logic [TAG_W-1:0]   req_tag;
    logic               req_ready;
    logic               flush;
    logic               wake_valid;
    logic [TAG_W-1:0]   wake_tag;
    logic               wb_valid;
    logic [TAG_W-1:0]   wb_tag;
    logic [2:0]         inflight;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output req_valid, req_op, req_tag, flush,
        input  req_ready, wake_valid, wake_tag, wb_valid, wb_tag, inflight, stall_cnt
    );

    modport slave (
        input  req_valid, req_op, req_tag, flush,
        output req_ready, wake_valid, wake_tag, wb_valid, wb_tag, inflight, stall_cnt
    );
endinterface

// File: rtl/fma_issue_scheduler.sv
// ----------------------------------------------------------------------------
// fma_issue_scheduler
// Issue-slot scheduler for one FMA slice (FMUL -> FADD, shared adder input,
// single writeback port). A reservation table indexed by "cycles from now"
// tracks adder-entry and writeback slots; an op is granted only when none of
// its slots are taken. Granted ops produce a wakeup one cycle before their
// writeback, and the writeback tag itself.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous reset, active-low
//   bus    : slave side of fma_issue_scheduler_if (request, flush, wake/wb,
//            inflight and stall counters)
// ----------------------------------------------------------------------------
module fma_issue_scheduler #(
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned ADD_LAT  = 2,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned MADD_OFF = 3,
    parameter int unsigned STALL_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fma_issue_scheduler_if.slave  bus
);
    localparam int unsigned H = MADD_OFF + ADD_LAT;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_MADD = 2'd2;

    // Slot k describes the cycle k cycles from now.
    logic [H:0]         r_add_busy;
    logic [H:0]         r_wb_busy;
    logic [H:0]         r_wb_live;
    logic [TAG_W-1:0]   r_wb_tag [0:H];
    logic [2:0]         r_inflight;
    logic [STALL_W-1:0] r_stall;

    logic               w_slot_ok;
    logic               w_ready;
    logic               w_issue;
    logic [H:0]         w_new_add;
    logic [H:0]         w_new_wb;
    logic [H:0]         w_add_d;
    logic [H:0]         w_wb_d;
    logic [H:0]         w_live_d;
    logic [TAG_W-1:0]   w_tag_d [0:H];

    // Collision check against the current table only; req_valid is not used
    // so there is no valid->ready path.
    always_comb begin
        w_slot_ok = 1'b0;
        case (bus.req_op)
            OP_ADD:  w_slot_ok = ~r_add_busy[0] & ~r_wb_busy[ADD_LAT];
            OP_MUL:  w_slot_ok = ~r_wb_busy[MUL_LAT];
            OP_MADD: w_slot_ok = ~r_add_busy[MADD_OFF] & ~r_wb_busy[H];
            default: w_slot_ok = 1'b0;
        endcase
    end

    assign w_ready = w_slot_ok & ~bus.flush & i_rst;
    assign w_issue = bus.req_valid & w_ready;

    always_comb begin
        w_new_add = '0;
        w_new_wb  = '0;
        if (w_issue) begin
            case (bus.req_op)
                OP_ADD: begin
                    w_new_add[0]       = 1'b1;
                    w_new_wb[ADD_LAT]  = 1'b1;
                end
                OP_MUL: begin
                    w_new_wb[MUL_LAT]  = 1'b1;
                end
                OP_MADD: begin
                    w_new_add[MADD_OFF] = 1'b1;
                    w_new_wb[H]         = 1'b1;
                end
                default: begin
                    w_new_add = '0;
                    w_new_wb  = '0;
                end
            endcase
        end
    end

    // Shift the table one slot toward "now", merging this cycle's reservation.
    // Flush drops live bits but keeps busy bits: squashed ops still drain.
    always_comb begin
        w_add_d  = '0;
        w_wb_d   = '0;
        w_live_d = '0;
        for (int unsigned k = 0; k <= H; k++) begin
            w_tag_d[k] = '0;
        end
        for (int unsigned k = 0; k < H; k++) begin
            w_add_d[k]  = r_add_busy[k+1] | w_new_add[k+1];
            w_wb_d[k]   = r_wb_busy[k+1] | w_new_wb[k+1];
            w_live_d[k] = (r_wb_live[k+1] & ~bus.flush) | w_new_wb[k+1];
            w_tag_d[k]  = w_new_wb[k+1] ? bus.req_tag : r_wb_tag[k+1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_add_busy <= '0;
            r_wb_busy  <= '0;
            r_wb_live  <= '0;
            for (int unsigned k = 0; k <= H; k++) begin
                r_wb_tag[k] <= '0;
            end
        end else begin
            r_add_busy <= w_add_d;
            r_wb_busy  <= w_wb_d;
            r_wb_live  <= w_live_d;
            for (int unsigned k = 0; k <= H; k++) begin
                r_wb_tag[k] <= w_tag_d[k];
            end
        end
    end

    // Squashed ops keep counting until their writeback slot drains.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, r_wb_busy[0]})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_stall <= '0;
        end else if (bus.req_valid && !w_ready && (r_stall != {STALL_W{1'b1}})) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.wb_valid   = r_wb_busy[0] & r_wb_live[0];
    assign bus.wb_tag     = r_wb_tag[0];
    assign bus.wake_valid = r_wb_busy[1] & r_wb_live[1];
    assign bus.wake_tag   = r_wb_tag[1];
    assign bus.inflight   = r_inflight;
    assign bus.stall_cnt  = r_stall;
endmodule
